instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: four-state fetch loop that reads a 6-byte window,
// presents it to the decoder and advances the PC by the consumed length.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 48,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_window,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready,
  input  logic [2:0]            out_len,
  output logic                  len_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic                  capture;
  logic                  accept;
  logic                  err_set;

  function automatic logic len_legal(input logic [2:0] len);
    return (len == 3'd2) || (len == 3'd4) || (len == 3'd6);
  endfunction

  // Illegal lengths skip the whole window so the decoder can resynchronise.
  function automatic logic [ADDR_WIDTH-1:0] pc_advance(
    input logic [ADDR_WIDTH-1:0] cur,
    input logic [2:0]            len
  );
    logic [ADDR_WIDTH-1:0] step;
    step = len_legal(len) ? ADDR_WIDTH'(len) : ADDR_WIDTH'(3'd6);
    return cur + step;
  endfunction

  assign accept = (state == VALID) && out_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: state_nxt = WAIT;
      WAIT: begin
        state_nxt = VALID;
        capture   = 1'b1;
      end
      VALID: begin
        if (accept) begin
          state_nxt = FETCH;
          pc_nxt    = pc_advance(pc, out_len);
          err_set   = !len_legal(out_len);
        end
      end
    endcase
    // A redirect wins over everything, including a same-cycle acceptance;
    // the window is still consumed, so a bad length is still flagged.
    if (redirect_valid) begin
      state_nxt = FETCH;
      pc_nxt    = redirect_pc;
      capture   = 1'b0;
    end
  end

  // State / PC / captured window registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      out_window <= '0;
      out_pc     <= RESET_PC;
      len_error  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        out_window <= mem_data;
        out_pc     <= pc;
      end
      if (err_set) begin
        len_error <= 1'b1;
      end
    end
  end

  // Outputs decoded from registered state only
  assign mem_enable = (state == FETCH);
  assign mem_addr   = pc;
  assign out_valid  = (state == VALID);

endmodule
